// File: rtl/count_scheduler_if.sv
// count_scheduler_if: request/grant/count bundle between requesters and the
// shared count scheduler. The master side drives requests, the slave side
// (the scheduler) drives ownership, completion and count status.
interface count_scheduler_if #(
  parameter int NREQ = 4,
  parameter int CW   = 4
);
  logic [NREQ-1:0] req;        // level request per requester
  logic [NREQ-1:0] dir;        // 1 = count up, 0 = count down
  logic            hold;       // pauses counting while high
  logic [NREQ-1:0] grant;      // one-hot current owner
  logic [NREQ-1:0] ack;        // one-cycle completion pulse to owner
  logic            busy;       // counter owned (LOAD, RUN, DONE)
  logic [CW-1:0]   count;      // shared count value
  logic            tc;         // terminal count reached in RUN
  logic [7:0]      runs_done;  // completed-run statistic

  modport master (
    output req, dir, hold,
    input  grant, ack, busy, count, tc, runs_done
  );

  modport slave (
    input  req, dir, hold,
    output grant, ack, busy, count, tc, runs_done
  );
endinterface

// File: rtl/count_scheduler.sv
// count_scheduler: round-robin arbiter handing one shared up/down counter to
// NREQ requesters. A winner gets one LOAD cycle, a RUN phase that steps the
// count to its terminal value (pausable by hold), and a one-cycle DONE with
// ack. Dropping req before ack aborts the run without ack.
// Optional feature: define COUNT_SCHED_STATS_EN to enable the saturating
// runs_done counter; otherwise runs_done is tied to zero.
module count_scheduler #(
  parameter int NREQ      = 4,
  parameter int END_COUNT = 16,
  parameter int CW        = 4
) (
  input  logic             clk,
  input  logic             reset,   // synchronous, active-low
  count_scheduler_if.slave bus
);

  localparam int            IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] TOP = CW'(END_COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  state_e          state_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] ack_q;
  logic            busy_q;
  logic [CW-1:0]   count_q;
  logic            dir_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   last_q;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            at_term;
  logic            owner_req;

  // Terminal value depends on the direction latched at grant.
  assign at_term   = dir_q ? (count_q == TOP) : (count_q == '0);
  assign owner_req = bus.req[owner_q];

  // Round-robin search: first requester after last_q, wrapping modulo NREQ.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so
    // no path leaves it unassigned, which would infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Scheduler FSM with registered grant/ack/busy and the shared count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      dir_q   <= 1'b0;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      ack_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q <= S_LOAD;
            owner_q <= win_idx;
            grant_q <= NREQ'(1) << win_idx;
            dir_q   <= bus.dir[win_idx];
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!owner_req) begin
            // Abort: release without ack, count keeps its old value.
            state_q <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= owner_q;
          end else begin
            count_q <= dir_q ? '0 : TOP;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (!owner_req) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            last_q  <= owner_q;
          end else if (!bus.hold) begin
            if (at_term) begin
              state_q <= S_DONE;
              ack_q   <= grant_q;
            end else begin
              count_q <= dir_q ? count_q + CW'(1) : count_q - CW'(1);
            end
          end
        end
        S_DONE: begin
          // No arbitration here: the next grant is decided in IDLE.
          state_q <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          last_q  <= owner_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;
  assign bus.tc    = (state_q == S_RUN) && at_term;

`ifdef COUNT_SCHED_STATS_EN
  logic [7:0] runs_done_q;

  // Count completed runs (DONE cycles only), saturating at 255.
  always_ff @(posedge clk) begin
    if (!reset) begin
      runs_done_q <= '0;
    end else if (state_q == S_DONE && runs_done_q != 8'hFF) begin
      runs_done_q <= runs_done_q + 8'd1;
    end
  end

  assign bus.runs_done = runs_done_q;
`else
  assign bus.runs_done = 8'h00;
`endif

endmodule

// File: tb/tb_count_scheduler.sv
// tb_count_scheduler: table-driven single runs, hand sequences for round
// robin, hold, abort and mid-run reset, randomized traffic and the stats
// counter, all cross-checked every cycle against a run-progress model.
module tb_count_scheduler;

  localparam int NREQ = 4;
  localparam int END  = 16;
  localparam int CW   = 4;

`ifdef COUNT_SCHED_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  count_scheduler_if #(.NREQ(NREQ), .CW(CW)) bus ();

  count_scheduler #(.NREQ(NREQ), .END_COUNT(END), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: a run is described by its owner and a progress index p
  // (0 = load cycle, 1..END = run cycles, END+1 = completion cycle).
  int m_owner = -1;
  int m_p     = 0;
  int m_last  = NREQ - 1;
  int m_count = 0;
  int m_runs  = 0;
  bit m_dir   = 1'b0;

  function automatic int m_run_count();
    if (m_owner < 0 || m_p == 0) return m_count;
    if (m_p > END) return m_dir ? END - 1 : 0;
    return m_dir ? m_p - 1 : END - m_p;
  endfunction

  function automatic logic [NREQ-1:0] m_grant();
    return (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
  endfunction

  function automatic bit m_done();
    return (m_owner >= 0) && (m_p == END + 1);
  endfunction

  function automatic bit m_tc();
    return (m_owner >= 0) && (m_p == END);
  endfunction

  task automatic model_step();
    bit found;
    if (!reset) begin
      m_owner = -1; m_p = 0; m_last = NREQ - 1; m_count = 0; m_runs = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        int i;
        i = (m_last + k) % NREQ;
        if (!found && bus.req[i]) begin
          found = 1'b1; m_owner = i; m_dir = bus.dir[i]; m_p = 0;
        end
      end
    end else if (m_done()) begin
      m_count = m_run_count(); m_last = m_owner; m_owner = -1;
      if (STATS != 0 && m_runs < 255) m_runs++;
    end else if (!bus.req[m_owner]) begin
      m_count = m_run_count(); m_last = m_owner; m_owner = -1;
    end else if (m_p == 0 || !bus.hold) begin
      m_p++;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic compare_model();
    check("m_grant", bus.grant, m_grant());
    check("m_ack", bus.ack, m_done() ? m_grant() : '0);
    check("m_busy", bus.busy, m_owner >= 0);
    check("m_count", bus.count, m_run_count());
    check("m_tc", bus.tc, m_tc());
    check("m_runs_done", bus.runs_done, m_runs);
  endtask

  // One clock: model advances with the DUT at the edge, outputs compared at
  // the falling edge; callers change inputs only after tick returns.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare_model();
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    bus.req  = '0;
    bus.dir  = '0;
    bus.hold = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] dir;
    logic [NREQ-1:0] exp_grant;
    int              exp_first;
    int              exp_last;
  } vec_t;

  vec_t            vecs[5];
  logic [NREQ-1:0] rr_order[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t;
    bit  seen;

    vecs[0] = '{4'b0001, 4'b0001, 4'b0001, 0, 15};
    vecs[1] = '{4'b0010, 4'b0000, 4'b0010, 15, 0};
    vecs[2] = '{4'b1100, 4'b0100, 4'b0100, 0, 15};
    vecs[3] = '{4'b1000, 4'b0000, 4'b1000, 15, 0};
    vecs[4] = '{4'b0110, 4'b0010, 4'b0010, 0, 15};
    rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset    = 1'b0;
    bus.req  = '0;
    bus.dir  = '0;
    bus.hold = 1'b0;

    // Reset state.
    do_reset();
    check("rst_grant", bus.grant, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_count", bus.count, 0);
    check("rst_tc", bus.tc, 0);
    check("rst_runs_done", bus.runs_done, 0);

    // Single runs from reset: grant after one edge, 16 run cycles, ack at 18.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      bus.req = vecs[v].req;
      bus.dir = vecs[v].dir;
      tick();
      check("tbl_grant", bus.grant, vecs[v].exp_grant);
      check("tbl_busy", bus.busy, 1);
      tick();
      check("tbl_first", bus.count, vecs[v].exp_first);
      check("tbl_first_tc", bus.tc, 0);
      repeat (END - 1) tick();
      check("tbl_last", bus.count, vecs[v].exp_last);
      check("tbl_tc", bus.tc, 1);
      tick();
      check("tbl_ack", bus.ack, vecs[v].exp_grant);
      check("tbl_done_grant", bus.grant, vecs[v].exp_grant);
      bus.req = '0;
      tick();
      check("tbl_idle_busy", bus.busy, 0);
      check("tbl_idle_ack", bus.ack, 0);
    end

    // Round robin with all requesting; each drops on its ack, then re-raises.
    do_reset();
    bus.req = '1;
    bus.dir = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      t = 0;
      seen = 1'b0;
      while (!seen && t < 40) begin
        tick();
        t++;
        if (bus.ack != '0) seen = 1'b1;
      end
      check("rr_ack_seen", seen, 1);
      check("rr_grant", bus.grant, rr_order[i]);
      bus.req = bus.req & ~rr_order[i];
      tick();
      check("rr_gap_idle", bus.busy, 0);
      bus.req = '1;
    end
    bus.req = '0;
    tick();
    tick();

    // Hold for 5 cycles at count 7 delays ack by exactly 5 cycles.
    do_reset();
    bus.req = 4'b0001;
    bus.dir = 4'b0001;
    repeat (9) tick();
    check("hold_start", bus.count, 7);
    bus.hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_frozen", bus.count, 7);
    end
    bus.hold = 1'b0;
    t = 14;
    seen = 1'b0;
    while (!seen && t < 60) begin
      tick();
      t++;
      if (bus.ack == 4'b0001) seen = 1'b1;
    end
    check("hold_ack_cycle", t, 23);
    bus.req = '0;
    tick();

    // Abort at count 4: no ack, count held, requester 1 wins next.
    do_reset();
    bus.req = 4'b0011;
    bus.dir = 4'b0011;
    repeat (6) tick();
    check("abort_at", bus.count, 4);
    bus.req = 4'b0010;
    tick();
    check("abort_busy", bus.busy, 0);
    check("abort_ack", bus.ack, 0);
    check("abort_count", bus.count, 4);
    tick();
    check("abort_next_grant", bus.grant, 4'b0010);
    bus.req = '0;
    tick();
    tick();

    // Reset at count 9, then re-arbitration starts from requester 0.
    do_reset();
    bus.req = 4'b0001;
    bus.dir = 4'b0001;
    repeat (11) tick();
    check("mid_count", bus.count, 9);
    reset = 1'b0;
    tick();
    check("mid_rst_grant", bus.grant, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_tc", bus.tc, 0);
    check("mid_rst_ack", bus.ack, 0);
    reset = 1'b1;
    bus.req = 4'b0110;
    tick();
    check("mid_rearb_grant", bus.grant, 4'b0010);
    bus.req = '0;
    tick();
    tick();

    // Randomized traffic, including drops, holds and occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NREQ; b++) begin
        if (bus.req[b]) begin
          if ($urandom_range(0, 63) == 0) bus.req[b] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          bus.req[b] = 1'b1;
        end
      end
      if (m_done()) bus.req[m_owner] = 1'b0;
      bus.dir  = NREQ'($urandom);
      bus.hold = ($urandom_range(0, 7) == 0);
      reset    = ($urandom_range(0, 399) != 0);
      tick();
    end
    reset = 1'b1;

    // Stats: more than 255 completed runs back to back.
    do_reset();
    bus.req = 4'b0001;
    for (int i = 0; i < 300 * (END + 3) + 5; i++) begin
      bus.dir = NREQ'($urandom);
      tick();
    end
    check("stats_final", bus.runs_done, (STATS != 0) ? 255 : 0);
    bus.req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/count_scheduler.md
COUNT_SCHEDULER -- requirements
Module: count_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter END_COUNT, default 16, run length in counts (>=2).
REQ-003 Parameter CW, default 4, count width, ceil(log2(END_COUNT)).
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-low.
REQ-006 req  input  NREQ  level request per requester, held until its ack.
REQ-007 dir  input  NREQ  direction per requester, 1=up, 0=down, sampled in IDLE at grant.
REQ-008 hold  input  1  pauses counting while high.
REQ-009 grant  output  NREQ  one-hot owner of the counter, zero when not owned.
REQ-010 ack  output  NREQ  one-cycle completion pulse to the owner.
REQ-011 busy  output  1  high in LOAD, RUN and DONE.
REQ-012 count  output  CW  current shared count.
REQ-013 tc  output  1  terminal count flag.
REQ-014 runs_done  output  8  completed-run counter (see Configuration).

Function
REQ-015 FSM states: IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from registers only, with no combinational path from inputs.
REQ-016 IDLE: if req!=0, select the winner round-robin, starting at last+1 modulo NREQ, latch its dir and go to LOAD with grant one-hot set.
REQ-017 The last pointer resets to NREQ-1, so requester 0 wins first.
REQ-018 LOAD (1 cycle): count loads 0 for up, END_COUNT-1 for down. Go to RUN.
REQ-019 RUN, hold low, count not terminal: count steps +1 (up) or -1 (down).
REQ-020 RUN, hold high: count and state are frozen.
REQ-021 RUN, count at terminal (END_COUNT-1 up, 0 down) and hold low: go to DONE with no count step.
REQ-022 tc SHALL be high exactly when state=RUN and count is at terminal.
REQ-023 Latency with hold low: req seen at edge k gives LOAD in cycle k+1, RUN in k+2..k+END_COUNT+1, and DONE with ack in cycle k+END_COUNT+2.
REQ-024 DONE (1 cycle): ack bit of the owner high, grant still high. Set last to the owner, then return to IDLE. Arbitration resumes the next cycle, with no back-to-back grant in the DONE cycle.
REQ-025 Abort: if the owner's req drops in LOAD or RUN, return to IDLE next cycle.
  - no ack
  - last advances to the owner
  - count holds its value
REQ-026 Requests from non-owners are ignored while busy. They are not lost, because req is a level.
REQ-027 Count never wraps and always stays in 0..END_COUNT-1.

Reset
REQ-028 With reset low at a rising edge, the block SHALL reset:
  - state=IDLE, grant=0, ack=0, busy=0
  - count=0, tc=0, last=NREQ-1, runs_done=0
REQ-029 Reset mid-run SHALL abort without ack, and requests are re-arbitrated from requester 0.

Configuration
REQ-030 Macro COUNT_SCHED_STATS_EN defined: runs_done increments by 1 on each DONE cycle and saturates at 255. Aborts are not counted.
REQ-031 Macro COUNT_SCHED_STATS_EN undefined: runs_done is tied to 0, and no counter logic is present.

Verification
REQ-032 Single up run: req=0001, dir=0001, hold=0 → grant=0001 one cycle later. Count goes 0..15, tc at 15, ack=0001 in cycle 18 after req, busy then falls.
REQ-033 Down run: req=0010, dir=0000 → count goes 15..0, tc at 0, ack=0010 after 18 cycles.
REQ-034 Round robin: req=1111 held, each dropped on its ack → grant order 0,1,2,3,0. Each DONE is followed by one IDLE cycle.
REQ-035 Hold: hold=1 for 5 cycles at count=7 (up) → count stays 7 and ack is delayed by exactly 5 cycles.
REQ-036 Abort/reset: req0 drops at count=4 → IDLE, no ack, and the next grant goes to requester 1 if it is requesting. Reset low at count=9 → all outputs return to REQ-028 values.
REQ-037 Stats: 300 completed runs with COUNT_SCHED_STATS_EN defined → runs_done=255. Without the macro → runs_done=0 throughout.
